stopwatch_bcd_counter: RTL

//  Time-base stage directly upstream of the 16-bit time register. Counts MM:SS in packed BCD,
//  up or down. Has a start/pause/clear/load control FSM and an internal tick prescaler.
//  Q_time drives the register's D bus.

---
 rtl/stopwatch_bcd_counter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: MM:SS packed-BCD up/down stopwatch with start/pause/clear/load
//    control FSM and an internal 1 s tick prescaler (TICK_DIV core clock cycles per step).
// Latency: time steps on the edge where the prescaler wraps, TICK_DIV cycles after entering RUN.
// Backpressure: none; every control input is a one-cycle pulse acted on the edge it is seen.
// Optional feature: define STOPWATCH_LAP_EN to add the lap input (display freeze).
// Ports:
//   C, R                 clock, synchronous active-high reset
//   start_stop/clr/load  control pulses; load_val is the BCD value offered with load
//   dir                  0 = count up, 1 = count down (sampled on each tick)
//   lap                  level, freezes Q_time while high (STOPWATCH_LAP_EN only)
//   Q_time               registered BCD {min_t,min_u,sec_t,sec_u}
//   running/done         registered state decodes; wrap/load_err one-cycle pulses
module stopwatch_bcd_counter #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic        C,
   input  logic        R,
   input  logic        start_stop,
   input  logic        clr,
   input  logic        dir,
   input  logic        load,
   input  logic [15:0] load_val,
`ifdef STOPWATCH_LAP_EN
   input  logic        lap,
`endif
   output logic [15:0] Q_time,
   output logic        running,
   output logic        done,
   output logic        wrap,
   output logic        load_err
);

   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   time_q, time_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          wrap_q, wrap_d;
   logic          load_err_q, load_err_d;
   logic          running_q, done_q;
   logic          tick;
   logic          load_ok;
   logic [15:0]   dec_val;

   // Carries ripple digit by digit; 99:59 rolls naturally to 00:00.
   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [3:0] mt, mu, st, su;
      {mt, mu, st, su} = t;
      if (su != 4'd9) su = su + 4'd1;
      else begin
         su = 4'd0;
         if (st != 4'd5) st = st + 4'd1;
         else begin
            st = 4'd0;
            if (mu != 4'd9) mu = mu + 4'd1;
            else begin
               mu = 4'd0;
               mt = (mt == 4'd9) ? 4'd0 : mt + 4'd1;
            end
         end
      end
      return {mt, mu, st, su};
   endfunction

   // Only called for non-zero times, so min_t never borrows.
   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [3:0] mt, mu, st, su;
      {mt, mu, st, su} = t;
      if (su != 4'd0) su = su - 4'd1;
      else begin
         su = 4'd9;
         if (st != 4'd0) st = st - 4'd1;
         else begin
            st = 4'd5;
            if (mu != 4'd0) mu = mu - 4'd1;
            else begin
               mu = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mu, st, su};
   endfunction

   always_comb begin
      state_d    = state_q;
      time_d     = time_q;
      presc_d    = presc_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;

      load_ok = (load_val[15:12] <= 4'd9) && (load_val[11:8] <= 4'd9) &&
                (load_val[7:4] <= 4'd5) && (load_val[3:0] <= 4'd9);
      tick    = (state_q == S_RUN) && (presc_q == PW'(TICK_DIV - 1));
      dec_val = (time_q == 16'h0000) ? 16'h0000 : bcd_dec(time_q);

      // The prescaler keeps advancing on the pause edge; only the time step is dropped.
      if (state_q == S_RUN) presc_d = tick ? '0 : presc_q + PW'(1);

      if (clr) begin
         time_d  = 16'h0000;
         presc_d = '0;
         state_d = S_IDLE;
      end else if (load && (state_q != S_RUN)) begin
         // A load outside RUN consumes the cycle, so a coincident start_stop is dropped.
         if (load_ok) begin
            time_d  = load_val;
            presc_d = '0;
            if (state_q == S_DONE) state_d = S_IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (start_stop) begin
         case (state_q)
            S_IDLE, S_PAUSE: state_d = (dir && (time_q == 16'h0000)) ? S_DONE : S_RUN;
            S_RUN:           state_d = S_PAUSE;
            default:         state_d = state_q;
         endcase
      end else if (tick) begin
         if (!dir) begin
            time_d = bcd_inc(time_q);
            wrap_d = (time_q == 16'h9959);
         end else begin
            time_d = dec_val;
            if (dec_val == 16'h0000) state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge C) begin
      if (R) begin
         state_q    <= S_IDLE;
         time_q     <= 16'h0000;
         presc_q    <= '0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         presc_q    <= presc_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
         running_q  <= (state_d == S_RUN);
         done_q     <= (state_d == S_DONE);
      end
   end

`ifdef STOPWATCH_LAP_EN
   // Display register follows time_d so it matches time_q when not frozen.
   logic [15:0] disp_q;
   always_ff @(posedge C) begin
      if (R || clr)  disp_q <= 16'h0000;
      else if (!lap) disp_q <= time_d;
   end
   assign Q_time = disp_q;
`else
   assign Q_time = time_q;
`endif

   assign running  = running_q;
   assign done     = done_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule
